// File: rtl/btn_speed_ctrl.sv
// Push-button front end: synchronise, debounce and edge-detect three buttons,
// then drive a run/pause flag, a saturating speed level and a tick prescaler.
module btn_speed_ctrl #(
    parameter int DEB_CYCLES = 500000,
    parameter int SPEED_W    = 3,
    parameter int SPEED_RST  = 3,
    parameter int BASE_DIV   = 50000000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic               btn_pause,
    input  logic               btn_faster,
    input  logic               btn_slower,
    output logic               pause_evt,
    output logic               faster_evt,
    output logic               slower_evt,
    output logic               run,
    output logic [SPEED_W-1:0] speed_lvl,
    output logic               tick
);
    localparam int DEB_W = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
    localparam int DIV_W = $clog2(BASE_DIV);
    localparam logic [SPEED_W-1:0] SPEED_MAX = '1;

    // Bit 0 = pause, bit 1 = faster, bit 2 = slower throughout.
    logic [2:0]         sync1_q, sync1_d;
    logic [2:0]         sync2_q, sync2_d;
    logic [DEB_W-1:0]   deb_cnt_q [3];
    logic [DEB_W-1:0]   deb_cnt_d [3];
    logic [2:0]         stable_q, stable_d;
    logic [2:0]         stable_dly_q, stable_dly_d;
    logic [2:0]         evt_q, evt_d;
    logic               run_q, run_d;
    logic [SPEED_W-1:0] speed_q, speed_d;
    logic [DIV_W-1:0]   presc_q, presc_d;
    logic               tick_q, tick_d;
    logic [DIV_W-1:0]   presc_last;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            for (int i = 0; i < 3; i++) deb_cnt_q[i] <= '0;
            stable_q     <= '0;
            stable_dly_q <= '0;
            evt_q        <= '0;
            run_q        <= 1'b0;
            speed_q      <= SPEED_W'(SPEED_RST);
            presc_q      <= '0;
            tick_q       <= 1'b0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            for (int i = 0; i < 3; i++) deb_cnt_q[i] <= deb_cnt_d[i];
            stable_q     <= stable_d;
            stable_dly_q <= stable_dly_d;
            evt_q        <= evt_d;
            run_q        <= run_d;
            speed_q      <= speed_d;
            presc_q      <= presc_d;
            tick_q       <= tick_d;
        end
    end

    always_comb begin
        sync1_d      = sync1_q;
        sync2_d      = sync2_q;
        for (int i = 0; i < 3; i++) deb_cnt_d[i] = deb_cnt_q[i];
        stable_d     = stable_q;
        stable_dly_d = stable_dly_q;
        evt_d        = evt_q;
        run_d        = run_q;
        speed_d      = speed_q;
        presc_d      = presc_q;
        tick_d       = tick_q;
        presc_last   = DIV_W'((BASE_DIV >> speed_q) - 1);

        if (ena) begin
            sync1_d = {btn_slower, btn_faster, btn_pause};
            sync2_d = sync1_q;

            // Stable follows the synced level only after DEB_CYCLES straight mismatches.
            for (int i = 0; i < 3; i++) begin
                if (sync2_q[i] != stable_q[i]) begin
                    if (deb_cnt_q[i] == DEB_W'(DEB_CYCLES - 1)) begin
                        stable_d[i]  = ~stable_q[i];
                        deb_cnt_d[i] = '0;
                    end else begin
                        deb_cnt_d[i] = deb_cnt_q[i] + DEB_W'(1);
                    end
                end else begin
                    deb_cnt_d[i] = '0;
                end
            end

            stable_dly_d = stable_q;
            evt_d        = stable_q & ~stable_dly_q;
            run_d        = run_q ^ evt_q[0];

            if (evt_q[1] && !evt_q[2] && speed_q != SPEED_MAX) begin
                speed_d = speed_q + SPEED_W'(1);
            end else if (evt_q[2] && !evt_q[1] && speed_q != '0) begin
                speed_d = speed_q - SPEED_W'(1);
            end

            // A real level change restarts the period; a saturated press is a no-op.
            if (speed_d != speed_q) begin
                presc_d = '0;
                tick_d  = 1'b0;
            end else if (run_q) begin
                if (presc_q == presc_last) begin
                    presc_d = '0;
                    tick_d  = 1'b1;
                end else begin
                    presc_d = presc_q + DIV_W'(1);
                    tick_d  = 1'b0;
                end
            end else begin
                tick_d = 1'b0;
            end
        end
    end

    assign pause_evt  = evt_q[0] & ena;
    assign faster_evt = evt_q[1] & ena;
    assign slower_evt = evt_q[2] & ena;
    assign run        = run_q;
    assign speed_lvl  = speed_q;
    assign tick       = tick_q & ena;

endmodule

// File: tb/tb_btn_speed_ctrl.sv
// Randomised bench for btn_speed_ctrl: a behavioural model pushes the expected
// outputs of every clock edge into a queue; a monitor pops and compares them.
module tb_btn_speed_ctrl;
    localparam int DEB   = 4;
    localparam int SW    = 3;
    localparam int SRST  = 3;
    localparam int BASE  = 256;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ena;
    logic          btn_pause, btn_faster, btn_slower;
    logic          pause_evt, faster_evt, slower_evt;
    logic          run;
    logic [SW-1:0] speed_lvl;
    logic          tick;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];

    btn_speed_ctrl #(
        .DEB_CYCLES(DEB),
        .SPEED_W   (SW),
        .SPEED_RST (SRST),
        .BASE_DIV  (BASE)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .btn_pause (btn_pause),
        .btn_faster(btn_faster),
        .btn_slower(btn_slower),
        .pause_evt (pause_evt),
        .faster_evt(faster_evt),
        .slower_evt(slower_evt),
        .run       (run),
        .speed_lvl (speed_lvl),
        .tick      (tick)
    );

    always #5 clk = ~clk;

    // Reference model: a button is accepted once its synchronised level
    // (two sampled edges late) has been constant for DEB sampled edges.
    logic [2:0]    hist[$];
    logic [2:0]    m_stable, m_stable_prev, m_evt;
    logic          m_run, m_tick;
    logic [SW-1:0] m_spd;
    int            m_cnt;

    task automatic model_edge();
        logic [2:0]    new_stable;
        logic [2:0]    new_evt;
        logic          new_run;
        logic [SW-1:0] new_spd;
        int            n, period;
        bit            all1, all0;
        if (!rst_n) begin
            hist.delete();
            repeat (DEB + 2) hist.push_back(3'b000);
            m_stable = '0; m_stable_prev = '0; m_evt = '0;
            m_run = 1'b0; m_spd = SW'(SRST); m_cnt = 0; m_tick = 1'b0;
        end else if (ena) begin
            n = hist.size();
            for (int b = 0; b < 3; b++) begin
                all1 = 1'b1; all0 = 1'b1;
                for (int j = 0; j < DEB; j++) begin
                    if (hist[n-2-j][b]) all0 = 1'b0;
                    else                all1 = 1'b0;
                end
                new_stable[b] = all1 ? 1'b1 : (all0 ? 1'b0 : m_stable[b]);
            end
            new_evt = m_stable & ~m_stable_prev;
            new_run = m_run ^ m_evt[0];
            new_spd = m_spd;
            if (m_evt[1] && !m_evt[2] && m_spd < SW'(7)) new_spd = m_spd + 1'b1;
            if (m_evt[2] && !m_evt[1] && m_spd > SW'(0)) new_spd = m_spd - 1'b1;
            period = BASE >> m_spd;
            if (new_spd != m_spd) begin
                m_cnt = 0; m_tick = 1'b0;
            end else if (m_run) begin
                m_tick = (m_cnt == period - 1);
                m_cnt  = m_tick ? 0 : m_cnt + 1;
            end else begin
                m_tick = 1'b0;
            end
            m_stable_prev = m_stable;
            m_stable = new_stable;
            m_evt = new_evt;
            m_run = new_run;
            m_spd = new_spd;
            hist.push_back({btn_slower, btn_faster, btn_pause});
            if (hist.size() > DEB + 8) void'(hist.pop_front());
        end
        exp_q.push_back({m_evt, m_run, m_spd, m_tick});
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_edge();
        end
    end

    initial begin
        logic [7:0] e, a;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (!ena) begin
                    e[7:5] = 3'b000;
                    e[0]   = 1'b0;
                end
                a = {slower_evt, faster_evt, pause_evt, run, speed_lvl, tick};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL outputs t=%0t {evt[2:0],run,spd,tick} got %b want %b", $time, a, e);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic press(input logic [2:0] mask, input int len, input int gap);
        {btn_slower, btn_faster, btn_pause} = mask;
        step(len);
        {btn_slower, btn_faster, btn_pause} = 3'b000;
        step(gap);
    endtask

    initial begin
        logic [2:0] m;
        int r;
        rst_n = 1'b0; ena = 1'b1;
        {btn_slower, btn_faster, btn_pause} = 3'b000;
        step(10);
        rst_n = 1'b1;
        step(100);

        press(3'b001, 20, 100);          // start running at level 3
        press(3'b010, 3, 80);            // glitch, rejected
        repeat (5) press(3'b010, 10, 20);
        repeat (8) press(3'b100, 10, 20);
        press(3'b110, 10, 600);          // tie: level stays 0

        rst_n = 1'b0; step(1); rst_n = 1'b1; step(5);
        press(3'b001, 10, 40);           // run at level 3
        press(3'b001, 10, 30);           // pause mid-period
        press(3'b001, 10, 60);           // resume
        rst_n = 1'b0; step(1); rst_n = 1'b1; step(10);

        for (int it = 0; it < 250; it++) begin
            r = $urandom_range(0, 99);
            if (r < 4) begin
                rst_n = 1'b0; step(1); rst_n = 1'b1;
            end else if (r < 12) begin
                ena = 1'b0; step($urandom_range(1, 5)); ena = 1'b1;
            end else begin
                m = (r < 60) ? (3'b001 << $urandom_range(0, 2)) : 3'($urandom_range(1, 7));
                press(m, $urandom_range(1, 12), $urandom_range(1, 15));
            end
        end

        step(3);
        checks++;
        if (exp_q.size() > 1) begin
            errors++;
            $display("FAIL drain queue left %0d want <=1", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
